// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keyboard calculator sequencer (BCD operand entry, op chaining, ALU handshake)
// Define CALC_WDOG_EN to build a TIMEOUT-cycle watchdog on the ALU wait in CALC.
module calc_seq_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [11:0] alu_a,
  output logic [11:0] alu_b,
  input  logic        alu_done,
  input  logic [11:0] alu_result,
  input  logic        alu_err,
  output logic [11:0] disp_val,
  output logic        disp_err,
  output logic        busy,
  output logic [2:0]  state_dbg
);
  typedef enum logic [2:0] {ENTA = 3'd0, OPW = 3'd1, ENTB = 3'd2, CALC = 3'd3, RES = 3'd4, ERR = 3'd5} state_t;
  state_t      r_state;
  logic [11:0] r_a, r_b, r_res;
  logic [1:0]  r_cnt_a, r_cnt_b, r_op, r_pend_op;
  logic        r_pend, r_start;
  logic        w_clr, w_dig, w_opk, w_eq, w_a_skip, w_b_skip, w_wd_hit;
  logic [1:0]  w_op;
  assign w_clr = key_valid && key_code == 4'd15;
  assign w_dig = key_valid && key_code < 4'd10;
  assign w_opk = key_valid && key_code >= 4'd10 && key_code <= 4'd13;
  assign w_eq  = key_valid && key_code == 4'd14;
  // codes 10..13 map to ops 0..3
  assign w_op  = key_code[1:0] + 2'd2;
  // a full operand ignores further digits; a leading zero is not counted
  assign w_a_skip = r_cnt_a == 2'd3 || (key_code == 4'd0 && r_a == 12'h000);
  assign w_b_skip = r_cnt_b == 2'd3 || (key_code == 4'd0 && r_b == 12'h000);
`ifdef CALC_WDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] r_wd;
  assign w_wd_hit = r_wd == WDW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wd <= '0;
    else r_wd <= (r_state == CALC) ? r_wd + 1'b1 : '0;
  end
`else
  assign w_wd_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ENTA;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      r_op      <= '0;
      r_pend_op <= '0;
      r_pend    <= 1'b0;
      r_start   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_clr) begin
        r_state   <= ENTA;
        r_a       <= '0;
        r_b       <= '0;
        r_cnt_a   <= '0;
        r_cnt_b   <= '0;
        r_op      <= '0;
        r_pend_op <= '0;
        r_pend    <= 1'b0;
      end else begin
        case (r_state)
          ENTA: begin
            if (w_dig && !w_a_skip) begin
              r_a     <= {r_a[7:0], key_code};
              r_cnt_a <= r_cnt_a + 2'd1;
            end else if (w_opk) begin
              r_op    <= w_op;
              r_state <= OPW;
            end
          end
          OPW: begin
            if (w_opk) r_op <= w_op;
            else if (w_dig) begin
              r_b     <= {8'h00, key_code};
              r_cnt_b <= {1'b0, key_code != 4'd0};
              r_state <= ENTB;
            end
          end
          ENTB: begin
            if (w_dig && !w_b_skip) begin
              r_b     <= {r_b[7:0], key_code};
              r_cnt_b <= r_cnt_b + 2'd1;
            end else if (w_eq || w_opk) begin
              r_start   <= 1'b1;
              r_pend    <= w_opk;
              r_pend_op <= w_op;
              r_state   <= CALC;
            end
          end
          CALC: begin
            if (alu_done) begin
              if (alu_err) r_state <= ERR;
              else if (r_pend) begin
                r_a     <= alu_result;
                r_op    <= r_pend_op;
                r_b     <= '0;
                r_cnt_b <= '0;
                r_pend  <= 1'b0;
                r_state <= OPW;
              end else begin
                r_res   <= alu_result;
                r_state <= RES;
              end
            end else if (w_wd_hit) r_state <= ERR;
          end
          RES: begin
            if (w_dig) begin
              r_a     <= {8'h00, key_code};
              r_cnt_a <= {1'b0, key_code != 4'd0};
              r_b     <= '0;
              r_cnt_b <= '0;
              r_state <= ENTA;
            end else if (w_opk) begin
              r_a     <= r_res;
              r_op    <= w_op;
              r_state <= OPW;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign alu_start = r_start;
  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign busy      = r_state == CALC;
  assign disp_err  = r_state == ERR;
  assign state_dbg = r_state;
  assign disp_val  = (r_state == ENTA || r_state == OPW) ? r_a :
                     (r_state == ENTB || r_state == CALC) ? r_b :
                     (r_state == RES) ? r_res : 12'h000;
endmodule
